// File: rtl/comb_pkg.sv
// Shared definitions for the comb block: operation codes and the default
// constant set selected by MyConstantSelect.
package comb_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  localparam logic [7:0] K0_DEF = 8'd1;
  localparam logic [7:0] K1_DEF = 8'd16;
  localparam logic [7:0] K2_DEF = 8'd100;
  localparam logic [7:0] K3_DEF = 8'd255;

endpackage

// File: rtl/comb_alu.sv
// Purely combinational ALU: result and per-operation status from A, K and op.
module comb_alu
  import comb_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] k,
  input  op_e        op,
  output logic [7:0] result,
  output logic       status
);

  logic [8:0] sum_s;
  logic [8:0] diff_s;
  logic [7:0] and_s;
  logic [7:0] xor_s;

  // Operation select; bit 8 of the 9-bit sum/difference is carry/borrow
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, k};
    diff_s = {1'b0, a} - {1'b0, k};
    and_s  = a & k;
    xor_s  = a ^ k;
    result = 8'd0;
    status = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_s[7:0];
        status = sum_s[8];
      end
      OP_SUB: begin
        result = diff_s[7:0];
        status = diff_s[8];
      end
      OP_AND: begin
        result = and_s;
        status = (and_s == 8'd0);
      end
      OP_XOR: begin
        result = xor_s;
        status = (xor_s == 8'd0);
      end
      default: begin
        result = 8'd0;
        status = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/comb.sv
// comb top: constant mux feeding comb_alu, with registered result and status
// (one cycle latency, synchronous active-low reset).
module comb
  import comb_pkg::*;
#(
  parameter logic [7:0] K0 = K0_DEF,
  parameter logic [7:0] K1 = K1_DEF,
  parameter logic [7:0] K2 = K2_DEF,
  parameter logic [7:0] K3 = K3_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] MyInput,
  input  logic [1:0] MyConstantSelect,
  input  logic [1:0] MyOperation,
  output logic       MyStatus,
  output logic [7:0] MyOutput
);

  logic [7:0] k_s;
  logic [7:0] result_s;
  logic       status_s;

  // All four selects map to a constant, so a plain two-level mux suffices
  assign k_s = MyConstantSelect[1] ? (MyConstantSelect[0] ? K3 : K2)
                                   : (MyConstantSelect[0] ? K1 : K0);

  comb_alu u_alu (
    .a      (MyInput),
    .k      (k_s),
    .op     (op_e'(MyOperation)),
    .result (result_s),
    .status (status_s)
  );

  // Output registers; reset wins over any operation presented in the same cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      MyOutput <= 8'd0;
      MyStatus <= 1'b0;
    end else begin
      MyOutput <= result_s;
      MyStatus <= status_s;
    end
  end

endmodule

// File: tb/tb_comb.sv
// Self-checking bench for comb: vector table, reset sequences and random
// vectors, all checked through an expected-value queue.
module tb_comb;

  logic       clk;
  logic       reset_n;
  logic [7:0] MyInput;
  logic [1:0] MyConstantSelect;
  logic [1:0] MyOperation;
  logic       MyStatus;
  logic [7:0] MyOutput;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [1:0] sel;
    logic [1:0] op;
    logic [7:0] out;
    logic       st;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       st;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  comb dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .MyInput          (MyInput),
    .MyConstantSelect (MyConstantSelect),
    .MyOperation      (MyOperation),
    .MyStatus         (MyStatus),
    .MyOutput         (MyOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, out=%0d st=%0d", MyOutput, MyStatus);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [7:0] a, input logic [1:0] sel, input logic [1:0] op,
                              input logic [7:0] out, input logic st, input string name);
    vec_t v;
    v.a = a; v.sel = sel; v.op = op; v.out = out; v.st = st; v.name = name;
    return v;
  endfunction

  // Independent reference: integer arithmetic on the default constants
  function automatic exp_t model(input int a, input int sel, input int op);
    int k;
    int r;
    exp_t e;
    case (sel)
      0: k = 1;
      1: k = 16;
      2: k = 100;
      default: k = 255;
    endcase
    case (op)
      0: begin r = a + k; e.st = (r > 255); r = r % 256; end
      1: begin r = a - k; e.st = (a < k); if (r < 0) r = r + 256; end
      2: begin r = a & k; e.st = (r == 0); end
      default: begin r = a ^ k; e.st = (r == 0); end
    endcase
    e.out = 8'(r);
    e.name = "random";
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got out=%0d st=%0d with nothing expected", MyOutput, MyStatus);
    end else begin
      e = sb.pop_front();
      if (MyOutput !== e.out || MyStatus !== e.st) begin
        n_fail++;
        $display("FAIL %s: got out=%0d st=%0d, expected out=%0d st=%0d",
                 e.name, MyOutput, MyStatus, e.out, e.st);
      end
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, check after the edge
  task automatic apply(input logic rst_n, input logic [7:0] a, input logic [1:0] sel,
                       input logic [1:0] op, input logic [7:0] out, input logic st,
                       input string name);
    exp_t e;
    @(negedge clk);
    reset_n          = rst_n;
    MyInput          = a;
    MyConstantSelect = sel;
    MyOperation      = op;
    e.out = out; e.st = st; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    exp_t m;
    reset_n = 1'b0;
    MyInput = 8'd0;
    MyConstantSelect = 2'd0;
    MyOperation = 2'd0;

    vecs.push_back(mk(8'd250, 2'd0, 2'd0, 8'd251, 1'b0, "add250_k0"));
    vecs.push_back(mk(8'd250, 2'd1, 2'd0, 8'd10,  1'b1, "add250_k1"));
    vecs.push_back(mk(8'd250, 2'd2, 2'd0, 8'd94,  1'b1, "add250_k2"));
    vecs.push_back(mk(8'd250, 2'd3, 2'd0, 8'd249, 1'b1, "add250_k3"));
    vecs.push_back(mk(8'd5,   2'd0, 2'd1, 8'd4,   1'b0, "sub5_k0"));
    vecs.push_back(mk(8'd5,   2'd1, 2'd1, 8'd245, 1'b1, "sub5_k1"));
    vecs.push_back(mk(8'd5,   2'd2, 2'd1, 8'd161, 1'b1, "sub5_k2"));
    vecs.push_back(mk(8'd5,   2'd3, 2'd1, 8'd6,   1'b1, "sub5_k3"));
    vecs.push_back(mk(8'd150, 2'd0, 2'd1, 8'd149, 1'b0, "sub150_k0"));
    vecs.push_back(mk(8'd150, 2'd1, 2'd1, 8'd134, 1'b0, "sub150_k1"));
    vecs.push_back(mk(8'd150, 2'd2, 2'd1, 8'd50,  1'b0, "sub150_k2"));
    vecs.push_back(mk(8'd150, 2'd3, 2'd1, 8'd151, 1'b1, "sub150_k3"));
    vecs.push_back(mk(8'd0,   2'd0, 2'd2, 8'd0,   1'b1, "and0_k0"));
    vecs.push_back(mk(8'd150, 2'd1, 2'd2, 8'd16,  1'b0, "and150_k1"));
    vecs.push_back(mk(8'd150, 2'd2, 2'd2, 8'd4,   1'b0, "and150_k2"));
    vecs.push_back(mk(8'd150, 2'd3, 2'd2, 8'd150, 1'b0, "and150_k3"));
    vecs.push_back(mk(8'd150, 2'd0, 2'd3, 8'd151, 1'b0, "xor150_k0"));
    vecs.push_back(mk(8'd150, 2'd1, 2'd3, 8'd134, 1'b0, "xor150_k1"));
    vecs.push_back(mk(8'd150, 2'd2, 2'd3, 8'd242, 1'b0, "xor150_k2"));
    vecs.push_back(mk(8'd150, 2'd3, 2'd3, 8'd105, 1'b0, "xor150_k3"));
    vecs.push_back(mk(8'd255, 2'd3, 2'd3, 8'd0,   1'b1, "xor255_k3"));
    vecs.push_back(mk(8'd255, 2'd0, 2'd0, 8'd0,   1'b1, "bnd_add255_k1"));
    vecs.push_back(mk(8'd16,  2'd1, 2'd1, 8'd0,   1'b0, "bnd_sub_a_eq_k"));
    vecs.push_back(mk(8'd0,   2'd3, 2'd1, 8'd1,   1'b1, "bnd_sub0_k255"));

    // Reset holds outputs at zero even with a carry-producing operation applied
    apply(1'b0, 8'd255, 2'd0, 2'd0, 8'd0, 1'b0, "reset_add");
    apply(1'b0, 8'd5,   2'd1, 2'd1, 8'd0, 1'b0, "reset_sub");

    // First released edge reflects its own inputs; then the table streams back to back
    foreach (vecs[i])
      apply(1'b1, vecs[i].a, vecs[i].sel, vecs[i].op, vecs[i].out, vecs[i].st, vecs[i].name);

    // Mid-stream reset discards the pending result, then latency resumes
    apply(1'b1, 8'd250, 2'd1, 2'd0, 8'd10,  1'b1, "pre_reset");
    apply(1'b0, 8'd5,   2'd3, 2'd1, 8'd0,   1'b0, "mid_reset");
    apply(1'b1, 8'd150, 2'd2, 2'd3, 8'd242, 1'b0, "post_reset_first");
    apply(1'b1, 8'd150, 2'd3, 2'd1, 8'd151, 1'b1, "post_reset_second");

    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra;
      logic [1:0] rs;
      logic [1:0] ro;
      ra = 8'($urandom_range(255, 0));
      rs = 2'($urandom_range(3, 0));
      ro = 2'($urandom_range(3, 0));
      m = model(int'(ra), int'(rs), int'(ro));
      apply(1'b1, ra, rs, ro, m.out, m.st, "random");
    end

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
